prog_loader_ctrl: RTL and testbench

Sequences the boot-time program load into instruction/data memory. It accepts a byte stream over a valid/ready handshake, assembles the bytes little-endian into 32-bit words, and issues one-cycle memory writes with byte enables. It holds the CPU in reset until the image is complete. It sits between the UART receiver and the memory write port, and owns the byte/word address count for the load.

---
 rtl/prog_loader_ctrl_if.sv | 17 +
 rtl/prog_loader_ctrl.sv | 122 ++++++++++++
 tb/tb_prog_loader_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_ctrl_if.sv
// Byte stream in, word-write port out, as seen between the UART receiver,
// the program loader and the memory write port.
interface prog_loader_ctrl_if;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;

   // master: the loader controller; slave: the stream source plus memory port
   modport master (input s_valid, s_data,
                   output s_ready, mem_we, mem_addr, mem_wdata, mem_be);
   modport slave  (output s_valid, s_data,
                   input s_ready, mem_we, mem_addr, mem_wdata, mem_be);
endinterface

// File: rtl/prog_loader_ctrl.sv
// Boot-time program loader: packs a byte stream little-endian into 32-bit
// words, writes them with byte enables and holds the CPU in reset until done.
module prog_loader_ctrl #(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [ADDR_W-1:0] len,
   prog_loader_ctrl_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_rstn
);
   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-3:0] BASE_ONE = (ADDR_W-2)'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-3:0] base_q, base_d;
   logic [31:0]       lane_buf_q, lane_buf_d;
   logic [3:0]        be_q, be_d;
   logic              err_q, err_d;
   logic              cpu_rstn_q, cpu_rstn_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         len_q      <= '0;
         cnt_q      <= '0;
         base_q     <= '0;
         lane_buf_q <= '0;
         be_q       <= '0;
         err_q      <= 1'b0;
         cpu_rstn_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         base_q     <= base_d;
         lane_buf_q <= lane_buf_d;
         be_q       <= be_d;
         err_q      <= err_d;
         cpu_rstn_q <= cpu_rstn_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      base_d     = base_q;
      lane_buf_d = lane_buf_q;
      be_d       = be_q;
      err_d      = 1'b0;
      cpu_rstn_d = cpu_rstn_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  len_d      = len;
                  cnt_d      = '0;
                  base_d     = '0;
                  lane_buf_d = '0;
                  be_d       = '0;
                  cpu_rstn_d = 1'b0;
                  state_d    = LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (bus.s_valid) begin
               lane_buf_d[8*cnt_q[1:0] +: 8] = bus.s_data;
               be_d[cnt_q[1:0]]              = 1'b1;
               cnt_d                         = cnt_q + CNT_ONE;
               // a full word or the final byte of the image triggers a write
               if (cnt_q[1:0] == 2'd3 || cnt_d == len_q) begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            lane_buf_d = '0;
            be_d       = '0;
            base_d     = base_q + BASE_ONE;
            if (cnt_q == len_q) begin
               cpu_rstn_d = 1'b1;
               state_d    = DONE;
            end else begin
               state_d = LOAD;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // write-port fields are forced to zero outside the single WRITE cycle
   always_comb begin
      bus.s_ready   = (state_q == LOAD);
      bus.mem_we    = (state_q == WRITE);
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_be    = '0;
      if (state_q == WRITE) begin
         bus.mem_addr  = {{(32-ADDR_W){1'b0}}, base_q, 2'b00};
         bus.mem_wdata = lane_buf_q;
         bus.mem_be    = be_q;
      end
   end

   assign busy     = (state_q == LOAD) || (state_q == WRITE);
   assign done     = (state_q == DONE);
   assign err      = err_q;
   assign cpu_rstn = cpu_rstn_q;
endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Randomized bench for prog_loader_ctrl: expected writes are derived from the
// image bytes by plain word/lane arithmetic and matched against the write port.
module tb_prog_loader_ctrl;
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic       start;
   logic [6:0] len;
   logic       busy, done, err, cpu_rstn;

   prog_loader_ctrl_if bus();

   prog_loader_ctrl #(.ADDR_W(7)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .len      (len),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .cpu_rstn (cpu_rstn)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_err    = 0;
   int         done_cnt = 0;
   bit         done_exp = 1'b0;
   logic [7:0] stim_q[$];
   bit         pat_q[$];
   wr_t        exp_q[$];
   wr_t        mon_e;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // image bytes -> expected word writes
   task automatic build_model(input int n);
      wr_t e;
      exp_q.delete();
      for (int w = 0; w * 4 < n; w++) begin
         e.addr = 32'(w * 4);
         e.data = '0;
         e.be   = '0;
         for (int l = 0; l < 4 && w * 4 + l < n; l++) begin
            e.data = e.data | (32'(stim_q[w * 4 + l]) << (8 * l));
            e.be   = e.be | 4'(1 << l);
         end
         exp_q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         check("done_pulse", 32'(done), 32'(done_exp));
         if (done) begin
            done_cnt++;
            check("cpu_rstn_on_done", 32'(cpu_rstn), 1);
         end
         done_exp = 1'b0;
         if (bus.mem_we) begin
            $display("wr addr=0x%08h data=0x%08h be=%04b", bus.mem_addr, bus.mem_wdata, bus.mem_be);
            check("s_ready_in_write", 32'(bus.s_ready), 0);
            if (exp_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", bus.mem_addr, mon_e.addr);
               check("wr_data", bus.mem_wdata, mon_e.data);
               check("wr_be", 32'(bus.mem_be), 32'(mon_e.be));
               done_exp = (exp_q.size() == 0);
            end
         end else begin
            check("idle_bus_zero", bus.mem_addr | bus.mem_wdata | 32'(bus.mem_be), 0);
         end
      end
   end

   task automatic fill_random(input int n);
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_cpu_rstn"}, 32'(cpu_rstn), 0);
      check({tag, "_s_ready"}, 32'(bus.s_ready), 0);
      check({tag, "_mem_we"}, 32'(bus.mem_we), 0);
      check({tag, "_bus"}, bus.mem_addr | bus.mem_wdata | 32'(bus.mem_be), 0);
   endtask

   task automatic run_load(input int n, input int gap_pct, input int poke_at,
                           input int abort_at, input bit use_pat);
      int idx;
      int cyc;
      int d0;
      bit v;
      bit poked;
      build_model(n);
      d0    = done_cnt;
      poked = 1'b0;
      @(negedge clk);
      start = 1'b1;
      len   = 7'(n);
      @(negedge clk);
      start = 1'b0;
      len   = 7'($urandom);
      check("busy_after_start", 32'(busy), 1);
      check("cpu_rstn_in_load", 32'(cpu_rstn), 0);
      check("s_ready_in_load", 32'(bus.s_ready), 1);
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 4000) begin
         if (idx == abort_at) break;
         if (idx == poke_at && !poked) begin
            start = 1'b1;
            len   = 7'd9;
            poked = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (use_pat) v = (pat_q.size() > 0) ? pat_q.pop_front() : 1'b1;
         else         v = ($urandom_range(99) >= 32'(gap_pct));
         bus.s_valid = v;
         if (v && bus.s_ready) begin
            bus.s_data = stim_q[idx];
            idx++;
         end else begin
            bus.s_data = 8'($urandom);
            if (use_pat && !v) check("s_ready_gap", 32'(bus.s_ready), 1);
         end
         @(negedge clk);
         cyc++;
      end
      bus.s_valid = 1'b0;
      start       = 1'b0;
      if (cyc >= 4000) check("stream_timeout", 0, 1);
      if (idx == abort_at) begin
         #2 rstn = 1'b0;
         #1 check_all_zero("async_reset");
         exp_q.delete();
         done_exp = 1'b0;
         @(negedge clk);
         #2 rstn = 1'b1;
         $display("load len=%0d aborted after %0d bytes", n, idx);
         return;
      end
      for (cyc = 0; cyc < 20 && done_cnt == d0; cyc++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("done_once", 32'(done_cnt - d0), 1);
      check("writes_left", 32'(exp_q.size()), 0);
      check("cpu_rstn_after_done", 32'(cpu_rstn), 1);
      check("busy_after_done", 32'(busy), 0);
      $display("load len=%0d complete", n);
   endtask

   initial begin
      logic c0;
      rstn        = 1'b0;
      start       = 1'b0;
      len         = '0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      #3 check_all_zero("reset");
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      stim_q.delete();
      for (int i = 1; i <= 8; i++) stim_q.push_back(8'(i));
      run_load(8, 0, -1, -1, 1'b0);

      stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      run_load(5, 0, -1, -1, 1'b0);

      fill_random(4);
      pat_q = '{1, 0, 0, 1, 1, 0, 1};
      run_load(4, 0, -1, -1, 1'b1);

      c0 = cpu_rstn;
      @(negedge clk);
      start = 1'b1;
      len   = 7'd0;
      @(negedge clk);
      start = 1'b0;
      check("err_pulse", 32'(err), 1);
      check("err_busy", 32'(busy), 0);
      check("err_cpu_rstn", 32'(cpu_rstn), 32'(c0));
      check("err_s_ready", 32'(bus.s_ready), 0);
      @(negedge clk);
      check("err_one_cycle", 32'(err), 0);
      $display("start len=0 err checked");

      fill_random(20);
      run_load(20, 30, 5, -1, 1'b0);

      fill_random(12);
      run_load(12, 0, -1, 6, 1'b0);
      fill_random(4);
      run_load(4, 0, -1, -1, 1'b0);

      fill_random(127);
      run_load(127, 0, -1, -1, 1'b0);

      for (int k = 0; k < 6; k++) begin
         int n;
         n = int'($urandom_range(127, 1));
         fill_random(n);
         run_load(n, int'($urandom_range(60)), -1, -1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 0, 1);
      $fatal(1, "simulation time limit reached");
   end
endmodule
